// File: rtl/lmmi_cfg_sequencer_pkg.sv
// Shared definitions for the LMMI configuration sequencer.
//   - FSM state encoding (IDLE/REQ/WAIT_RD/RSP), kept identical to the other
//     LMMI users so waveforms decode the same way everywhere.
//   - Default LMMI widths and timeout.
//   - ctr_width(): timeout counter width, never below 1 bit.
package lmmi_cfg_sequencer_pkg;

    localparam int LMMI_OFFSET_W = 7;
    localparam int LMMI_DATA_W   = 8;
    localparam int LMMI_TIMEOUT  = 255;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;
    localparam logic [1:0] ST_RSP     = 2'd3;

    // clog2(limit+1) is 0 when the timeout is disabled; keep a 1-bit counter
    // in that case so the port/vector widths stay legal.
    function automatic int ctr_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lmmi_timeout_ctr.sv
// Saturating cycle counter for LMMI operation timeouts.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   clr     in   restart count at 0 (new operation)
//   en      in   count this cycle (operation in flight)
//   expired out  this is the last allowed cycle (count == LIMIT-1 while en);
//                never asserted when LIMIT == 0
module lmmi_timeout_ctr #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] LAST = (LIMIT == 0) ? '1 : W'(LIMIT - 1);

    logic [W-1:0] cnt;

    // Saturate instead of wrapping: with the timeout disabled an operation can
    // sit in flight indefinitely and must not alias back to a small count.
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

    assign expired = (LIMIT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/lmmi_cfg_sequencer.sv
// LMMI master sequencer: takes a valid/ready stream of register read/write
// commands and runs them one at a time on an LMMI port, returning exactly one
// response (read data or write ack, plus timeout flag) per command.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cmd_valid/ready/write/offset/wdata   command stream in
//   rsp_valid/ready/data/err        response stream out (held until taken)
//   lmmi_request/wr_rdn/offset/wdata     LMMI request out
//   lmmi_ready/rdata/rdata_valid    LMMI handshake/data in
//   busy                            sequencer not idle
// Every output is a register or a decode of the state register, so there is
// no combinational path from any input to any output.
module lmmi_cfg_sequencer
    import lmmi_cfg_sequencer_pkg::*;
#(
    parameter int OFFSET_W = LMMI_OFFSET_W,
    parameter int DATA_W   = LMMI_DATA_W,
    parameter int TIMEOUT  = LMMI_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [OFFSET_W-1:0] cmd_offset,
    input  logic [DATA_W-1:0]   cmd_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic                lmmi_request,
    output logic                lmmi_wr_rdn,
    output logic [OFFSET_W-1:0] lmmi_offset,
    output logic [DATA_W-1:0]   lmmi_wdata,
    input  logic                lmmi_ready,
    input  logic [DATA_W-1:0]   lmmi_rdata,
    input  logic                lmmi_rdata_valid,
    output logic                busy
);

    localparam int CTR_W = ctr_width(TIMEOUT);

    logic [1:0] state;
    logic       accept;
    logic       in_flight;
    logic       expired;

    assign accept    = (state == ST_IDLE) && cmd_valid;
    assign in_flight = (state == ST_REQ) || (state == ST_WAIT_RD);

    lmmi_timeout_ctr #(
        .W     (CTR_W),
        .LIMIT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (in_flight),
        .expired (expired)
    );

    // The latched command drives the LMMI request fields directly, so they
    // cannot move while the request waits for lmmi_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            lmmi_wr_rdn <= 1'b0;
            lmmi_offset <= '0;
            lmmi_wdata  <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        lmmi_wr_rdn <= cmd_write;
                        lmmi_offset <= cmd_offset;
                        lmmi_wdata  <= cmd_wdata;
                        rsp_data    <= '0;
                        rsp_err     <= 1'b0;
                        state       <= ST_REQ;
                    end
                end
                // Completion is checked before expiry so a completion on the
                // final allowed cycle still succeeds. A read accepted on the
                // final cycle without data is not a completion and times out.
                ST_REQ: begin
                    if (lmmi_ready && lmmi_wr_rdn) begin
                        state <= ST_RSP;
                    end else if (lmmi_ready && lmmi_rdata_valid) begin
                        rsp_data <= lmmi_rdata;
                        state    <= ST_RSP;
                    end else if (expired) begin
                        rsp_err <= 1'b1;
                        state   <= ST_RSP;
                    end else if (lmmi_ready) begin
                        state <= ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    if (lmmi_rdata_valid) begin
                        rsp_data <= lmmi_rdata;
                        state    <= ST_RSP;
                    end else if (expired) begin
                        rsp_err <= 1'b1;
                        state   <= ST_RSP;
                    end
                end
                default: begin
                    if (rsp_ready)
                        state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign lmmi_request = (state == ST_REQ);
    assign rsp_valid    = (state == ST_RSP);

endmodule
